// File: rtl/ecc_pkg.sv
// Shared definitions for the APB-programmed SEC-DED engine: register map,
// op/width/result codes, FSM states and the width-code decoder.
package ecc_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_DATA_IN = 3'd1;
    localparam logic [2:0] REG_CW      = 3'd2;
    localparam logic [2:0] REG_NOISE   = 3'd3;
    localparam logic [2:0] REG_ERR_CNT = 3'd4;

    typedef enum logic [1:0] {
        OP_ENC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_FULL = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    localparam logic [1:0] CW_8  = 2'b00;
    localparam logic [1:0] CW_16 = 2'b01;
    localparam logic [1:0] CW_32 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENCODE = 3'd1,
        ST_NOISE  = 3'd2,
        ST_DECODE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] NERR_NONE   = 2'b00;
    localparam logic [1:0] NERR_SINGLE = 2'b01;
    localparam logic [1:0] NERR_DOUBLE = 2'b10;

    // Width code to codeword length, clamped to the instantiated maximum.
    function automatic logic [5:0] width_to_n(input logic [1:0] code, input logic [5:0] max_n);
        logic [5:0] n;
        case (code)
            CW_8:    n = 6'd8;
            CW_16:   n = 6'd16;
            CW_32:   n = 6'd32;
            default: n = 6'd32;
        endcase
        if (n > max_n) begin
            n = max_n;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/ecc_hamming_core.sv
// Combinational extended-Hamming encoder/decoder for a runtime codeword
// length n (8/16/32); bit i is Hamming position i+1, bit n-1 is overall parity.
module ecc_hamming_core
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [5:0]            n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] codeword_in,
    output logic [DATA_WIDTH-1:0] codeword_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            errors
);

    localparam int IW = $clog2(DATA_WIDTH);

    function automatic logic is_data_pos(input int i, input int nn);
        int pos;
        pos = i + 1;
        return (i < nn - 1) && ((pos & (pos - 1)) != 0);
    endfunction

    function automatic logic [4:0] syndrome(input logic [DATA_WIDTH-1:0] cw, input int nn);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < DATA_WIDTH - 1; i++) begin
            s = s ^ ((cw[i] && (i < nn - 1)) ? 5'(i + 1) : 5'd0);
        end
        return s;
    endfunction

    function automatic logic parity_below(input logic [DATA_WIDTH-1:0] cw, input int limit);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p = p ^ (cw[i] & (i < limit));
        end
        return p;
    endfunction

    int                    nn_s;
    logic [DATA_WIDTH-1:0] placed_s;
    logic [DATA_WIDTH-1:0] enc_s;
    logic [IW-1:0]         enc_k_s;
    logic [4:0]            enc_syn_s;
    logic                  enc_ovp_s;
    logic [4:0]            dec_syn_s;
    logic                  dec_par_s;
    int                    flip_s;
    logic [DATA_WIDTH-1:0] corr_s;
    logic [IW-1:0]         dec_k_s;

    assign nn_s = int'(n);

    // Encoder: scatter data LSB-first, fill parity from the syndrome of the data-only word.
    always_comb begin
        placed_s = '0;
        enc_k_s  = '0;
        for (int i = 0; i < DATA_WIDTH - 1; i++) begin
            placed_s[i] = is_data_pos(i, nn_s) ? data_in[enc_k_s] : 1'b0;
            enc_k_s     = enc_k_s + IW'(is_data_pos(i, nn_s));
        end
        enc_syn_s = syndrome(placed_s, nn_s);
        enc_s     = placed_s;
        for (int j = 0; (1 << j) < DATA_WIDTH; j++) begin
            enc_s[(1 << j) - 1] = ((1 << j) < nn_s) ? enc_syn_s[j] : placed_s[(1 << j) - 1];
        end
        enc_ovp_s = parity_below(enc_s, nn_s - 1);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            codeword_out[i] = (i == nn_s - 1) ? enc_ovp_s : enc_s[i];
        end
    end

    // Decoder: a zero syndrome with bad overall parity means the parity bit itself flipped.
    always_comb begin
        dec_syn_s = syndrome(codeword_in, nn_s);
        dec_par_s = parity_below(codeword_in, nn_s);
        flip_s    = (dec_syn_s != 5'd0) ? int'(dec_syn_s) - 1 : nn_s - 1;
        corr_s    = codeword_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            corr_s[i] = codeword_in[i] ^ (dec_par_s && (i == flip_s));
        end
        data_out = '0;
        dec_k_s  = '0;
        for (int i = 0; i < DATA_WIDTH - 1; i++) begin
            if (is_data_pos(i, nn_s)) begin
                data_out[dec_k_s] = corr_s[i];
                dec_k_s           = dec_k_s + IW'(1);
            end else begin
                dec_k_s = dec_k_s;
            end
        end
        errors = dec_par_s ? NERR_SINGLE : ((dec_syn_s != 5'd0) ? NERR_DOUBLE : NERR_NONE);
    end

endmodule

// File: rtl/ecc_apb_engine.sv
// APB front end, sequencing FSM and result registers for the SEC-DED engine.
// Optional saturating error counters behind `ECC_ERR_CNT_EN.
module ecc_apb_engine
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors,
    output logic                       busy
);

    state_e                state_r, state_next_s;
    op_e                   op_l_r;
    logic [5:0]            n_l_r;
    logic [DATA_WIDTH-1:0] work_r, noise_l_r;
    logic [1:0]            ctrl_op_r, cw_code_r;
    logic [DATA_WIDTH-1:0] data_in_r, noise_r;
    logic [AMBA_WORD-1:0]  prdata_r, rd_data_s, err_cnt_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [1:0]            nerr_r;
    logic                  done_r, busy_r;
    logic [2:0]            reg_sel_s;
    logic                  wr_en_s, rd_setup_s, start_s;
    logic [DATA_WIDTH-1:0] core_cw_s, core_data_s;
    logic [1:0]            core_err_s;
    logic                  unused_s;

    assign reg_sel_s  = PADDR[4:2];
    assign PREADY     = ~(PSEL & PWRITE & busy_r);
    assign wr_en_s    = PSEL & PENABLE & PWRITE & PREADY;
    assign rd_setup_s = PSEL & ~PENABLE & ~PWRITE;
    assign start_s    = wr_en_s && (reg_sel_s == REG_CTRL) && (PWDATA[1:0] != OP_NONE)
                        && (state_r == ST_IDLE);
    assign unused_s   = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA};

    ecc_hamming_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .n            (n_l_r),
        .data_in      (work_r),
        .codeword_in  (work_r),
        .codeword_out (core_cw_s),
        .data_out     (core_data_s),
        .errors       (core_err_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = (PWDATA[1:0] == OP_DEC) ? ST_DECODE : ST_ENCODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ENCODE: state_next_s = (op_l_r == OP_FULL) ? ST_NOISE : ST_DONE;
            ST_NOISE:  state_next_s = ST_DECODE;
            ST_DECODE: state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register with registered done/busy flags derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == ST_DONE);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // APB-writable configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_op_r <= 2'b00;
            data_in_r <= '0;
            cw_code_r <= 2'b00;
            noise_r   <= '0;
        end else if (wr_en_s) begin
            case (reg_sel_s)
                REG_CTRL:    ctrl_op_r <= PWDATA[1:0];
                REG_DATA_IN: data_in_r <= PWDATA[DATA_WIDTH-1:0];
                REG_CW:      cw_code_r <= PWDATA[1:0];
                REG_NOISE:   noise_r   <= PWDATA[DATA_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // Datapath: one working word carries data, then codeword, then noisy codeword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_l_r     <= OP_ENC;
            n_l_r      <= 6'd0;
            work_r     <= '0;
            noise_l_r  <= '0;
            data_out_r <= '0;
            nerr_r     <= NERR_NONE;
        end else if (start_s) begin
            op_l_r    <= op_e'(PWDATA[1:0]);
            n_l_r     <= width_to_n(cw_code_r, 6'(DATA_WIDTH));
            work_r    <= data_in_r;
            noise_l_r <= noise_r;
        end else begin
            case (state_r)
                ST_ENCODE: begin
                    work_r <= core_cw_s;
                    if (op_l_r == OP_ENC) begin
                        data_out_r <= core_cw_s;
                        nerr_r     <= NERR_NONE;
                    end
                end
                ST_NOISE:  work_r <= work_r ^ noise_l_r;
                ST_DECODE: begin
                    data_out_r <= core_data_s;
                    nerr_r     <= core_err_s;
                end
                default: ;
            endcase
        end
    end

`ifdef ECC_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] cnt_single_r, cnt_double_r;
    logic                     cnt_clr_s;

    assign cnt_clr_s = wr_en_s && (reg_sel_s == REG_ERR_CNT);
    assign err_cnt_s = AMBA_WORD'({cnt_single_r, cnt_double_r});

    // Saturating error counters; a clear write takes priority over an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_single_r <= '0;
            cnt_double_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_single_r <= '0;
            cnt_double_r <= '0;
        end else if (state_r == ST_DECODE) begin
            if ((core_err_s == NERR_SINGLE) && (cnt_single_r != '1)) begin
                cnt_single_r <= cnt_single_r + ERR_CNT_WIDTH'(1);
            end
            if ((core_err_s == NERR_DOUBLE) && (cnt_double_r != '1)) begin
                cnt_double_r <= cnt_double_r + ERR_CNT_WIDTH'(1);
            end
        end
    end
`else
    assign err_cnt_s = AMBA_WORD'({(2 * ERR_CNT_WIDTH){1'b0}});
`endif

    // Read mux.
    always_comb begin
        rd_data_s = '0;
        case (reg_sel_s)
            REG_CTRL:    rd_data_s = AMBA_WORD'(ctrl_op_r);
            REG_DATA_IN: rd_data_s = AMBA_WORD'(data_in_r);
            REG_CW:      rd_data_s = AMBA_WORD'(cw_code_r);
            REG_NOISE:   rd_data_s = AMBA_WORD'(noise_r);
            REG_ERR_CNT: rd_data_s = err_cnt_s;
            default:     rd_data_s = '0;
        endcase
    end

    // Read data is captured in the setup phase so it is stable throughout the access phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prdata_r <= '0;
        end else if (rd_setup_s) begin
            prdata_r <= rd_data_s;
        end
    end

    assign PRDATA         = prdata_r;
    assign data_out       = data_out_r;
    assign num_of_errors  = nerr_r;
    assign operation_done = done_r;
    assign busy           = busy_r;

endmodule
